// File: rtl/inst_queue_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | inst_queue_if : fetch / decode / issue bundle of inst_queue    Rev 1.0   |
// +--------------------------------------------------------------------------+
interface inst_queue_if #(
   parameter int PTR_W = 3
) ();
   logic             flush;
   logic             in_valid_0;
   logic [31:0]      in_pc_0;
   logic [31:0]      in_inst_0;
   logic             in_valid_1;
   logic [31:0]      in_pc_1;
   logic [31:0]      in_inst_1;
   logic             in_ready;
   logic             out_valid_0;
   logic [31:0]      out_pc_0;
   logic [31:0]      out_inst_0;
   logic             out_is_br_0;
   logic             out_valid_1;
   logic [31:0]      out_pc_1;
   logic [31:0]      out_inst_1;
   logic             out_is_br_1;
   logic [1:0]       deq_num;
   logic [PTR_W:0]   count;

   modport master (
      output flush, in_valid_0, in_pc_0, in_inst_0, in_valid_1, in_pc_1, in_inst_1, deq_num,
      input  in_ready, out_valid_0, out_pc_0, out_inst_0, out_is_br_0,
             out_valid_1, out_pc_1, out_inst_1, out_is_br_1, count
   );

   modport slave (
      input  flush, in_valid_0, in_pc_0, in_inst_0, in_valid_1, in_pc_1, in_inst_1, deq_num,
      output in_ready, out_valid_0, out_pc_0, out_inst_0, out_is_br_0,
             out_valid_1, out_pc_1, out_inst_1, out_is_br_1, count
   );
endinterface
`default_nettype wire

// File: rtl/inst_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | inst_queue : 2-in/2-out instruction FIFO; INST_QUEUE_PREDECODE_EN adds   |
// | a stored branch predecode bit per entry.                       Rev 1.0   |
// +--------------------------------------------------------------------------+
module inst_queue #(
   parameter int DEPTH = 8,
   parameter int PTR_W = 3
) (
   input  wire logic   clk,
   input  wire logic   rst_n,
   inst_queue_if.slave q
);
   localparam logic [PTR_W:0]   c_READY_MAX = (PTR_W + 1)'(DEPTH - 2);
   localparam logic [PTR_W-1:0] c_PTR_ONE   = PTR_W'(1);

   logic [31:0]      r_pc   [DEPTH];
   logic [31:0]      r_inst [DEPTH];
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [PTR_W:0]   r_count;

   logic             w_in_ready;
   logic [1:0]       w_enq;
   logic [1:0]       w_deq_req;
   logic [1:0]       w_eff_deq;
   logic [PTR_W-1:0] w_tail_p1;
   logic [PTR_W-1:0] w_head_p1;
   logic [PTR_W:0]   w_count_nxt;

   // Readiness looks only at registered occupancy so fetch never sees a path from deq_num.
   assign w_in_ready  = (r_count <= c_READY_MAX);
   assign w_enq       = w_in_ready ? ({1'b0, q.in_valid_0} + {1'b0, q.in_valid_0 & q.in_valid_1})
                                   : 2'd0;
   assign w_deq_req   = q.deq_num[1] ? 2'd2 : q.deq_num;
   assign w_eff_deq   = (r_count < {{(PTR_W-1){1'b0}}, w_deq_req}) ? r_count[1:0] : w_deq_req;
   assign w_tail_p1   = r_tail + c_PTR_ONE;
   assign w_head_p1   = r_head + c_PTR_ONE;
   assign w_count_nxt = r_count + {{(PTR_W-1){1'b0}}, w_enq} - {{(PTR_W-1){1'b0}}, w_eff_deq};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_pc[i]   <= '0;
            r_inst[i] <= '0;
         end
      end else if (!q.flush) begin
         if (w_enq != 2'd0) begin
            r_pc[r_tail]   <= q.in_pc_0;
            r_inst[r_tail] <= q.in_inst_0;
         end
         if (w_enq == 2'd2) begin
            r_pc[w_tail_p1]   <= q.in_pc_1;
            r_inst[w_tail_p1] <= q.in_inst_1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (q.flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         r_head  <= r_head + PTR_W'(w_eff_deq);
         r_tail  <= r_tail + PTR_W'(w_enq);
         r_count <= w_count_nxt;
      end
   end

   assign q.in_ready    = w_in_ready;
   assign q.count       = r_count;
   assign q.out_valid_0 = (r_count != '0);
   assign q.out_valid_1 = (r_count > (PTR_W + 1)'(1));
   assign q.out_pc_0    = r_pc[r_head];
   assign q.out_inst_0  = r_inst[r_head];
   assign q.out_pc_1    = r_pc[w_head_p1];
   assign q.out_inst_1  = r_inst[w_head_p1];

`ifdef INST_QUEUE_PREDECODE_EN
   logic r_br [DEPTH];

   // Branches, jumps and register jumps; the issue logic pairs these with their delay slot.
   function automatic logic f_is_br(input logic [5:0] op, input logic [5:0] fn);
      logic v_br;
      v_br = 1'b0;
      case (op)
         6'b000001, 6'b000010, 6'b000011,
         6'b000100, 6'b000101, 6'b000110, 6'b000111: v_br = 1'b1;
         6'b000000: v_br = (fn == 6'b001000) || (fn == 6'b001001);
         default:   v_br = 1'b0;
      endcase
      return v_br;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_br[i] <= 1'b0;
         end
      end else if (!q.flush) begin
         if (w_enq != 2'd0) begin
            r_br[r_tail] <= f_is_br(q.in_inst_0[31:26], q.in_inst_0[5:0]);
         end
         if (w_enq == 2'd2) begin
            r_br[w_tail_p1] <= f_is_br(q.in_inst_1[31:26], q.in_inst_1[5:0]);
         end
      end
   end

   assign q.out_is_br_0 = r_br[r_head];
   assign q.out_is_br_1 = r_br[w_head_p1];
`else
   assign q.out_is_br_0 = 1'b0;
   assign q.out_is_br_1 = 1'b0;
`endif
endmodule
`default_nettype wire
